// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and fixed datapath widths shared by the ALU files.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 5'b00000,
        OP_SUB = 5'b00001,
        OP_AND = 5'b00010,
        OP_OR  = 5'b00011,
        OP_SLL = 5'b00100,
        OP_SRA = 5'b00101
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_adder.sv
// alu_adder: 32-bit two's-complement adder with carry-in.
// The overflow output compares the sign of the operand actually fed on b,
// so a subtract (b = ~B, cin = 1) gets the correct subtract-overflow rule.
module alu_adder
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    // Modulo-2^32 sum; the carry-out is intentionally dropped.
    always_comb begin
        sum = a + b + {{(DATA_W-1){1'b0}}, cin};
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end

endmodule : alu_adder

// File: rtl/alu.sv
// alu: single-cycle ALU with one output register stage.
// Optional shifter enabled by defining ALU_SHIFT_EN; without it the shift
// opcodes return zero and ctrl_shiftamt is ignored.
module alu
    import alu_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  data_operandA,
    input  logic [DATA_W-1:0]  data_operandB,
    input  logic [OP_W-1:0]    ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [DATA_W-1:0]  data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow
);

    logic [DATA_W-1:0] addsub_b_s;
    logic              addsub_cin_s;
    logic [DATA_W-1:0] addsub_sum_s;
    logic              addsub_ovf_s;
    logic [DATA_W-1:0] cmp_diff_s;
    logic              cmp_ovf_s;
    logic [DATA_W-1:0] shift_res_s;

    logic [DATA_W-1:0] result_d, result_q;
    logic              ne_d, ne_q;
    logic              lt_d, lt_q;
    logic              ovf_d, ovf_q;

    // ADD and SUB share this adder: SUB feeds ~B with carry-in 1.
    always_comb begin
        if (ctrl_ALUopcode == OP_SUB) begin
            addsub_b_s   = ~data_operandB;
            addsub_cin_s = 1'b1;
        end else begin
            addsub_b_s   = data_operandB;
            addsub_cin_s = 1'b0;
        end
    end

    alu_adder u_addsub (
        .a   (data_operandA),
        .b   (addsub_b_s),
        .cin (addsub_cin_s),
        .sum (addsub_sum_s),
        .ovf (addsub_ovf_s)
    );

    // Compare flags need A-B on every opcode, so a second instance always subtracts.
    alu_adder u_cmp (
        .a   (data_operandA),
        .b   (~data_operandB),
        .cin (1'b1),
        .sum (cmp_diff_s),
        .ovf (cmp_ovf_s)
    );

`ifdef ALU_SHIFT_EN
    // Barrel shifter: logical left with zero fill, arithmetic right with sign fill.
    always_comb begin
        if (ctrl_ALUopcode == OP_SLL) begin
            shift_res_s = data_operandA << ctrl_shiftamt;
        end else if (ctrl_ALUopcode == OP_SRA) begin
            shift_res_s = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
        end else begin
            shift_res_s = {DATA_W{1'b0}};
        end
    end
`else
    logic unused_shamt_s;
    // No shifter built; the shift amount is deliberately left unused.
    always_comb begin
        unused_shamt_s = ^ctrl_shiftamt;
        shift_res_s    = {DATA_W{1'b0}};
    end
`endif

    // Result mux and flag computation feeding the output register.
    always_comb begin
        result_d = {DATA_W{1'b0}};
        ovf_d    = 1'b0;
        ne_d     = (data_operandA != data_operandB);
        lt_d     = cmp_diff_s[DATA_W-1] ^ cmp_ovf_s;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                result_d = addsub_sum_s;
                ovf_d    = addsub_ovf_s;
            end
            OP_SUB: begin
                result_d = addsub_sum_s;
                ovf_d    = addsub_ovf_s;
            end
            OP_AND:  result_d = data_operandA & data_operandB;
            OP_OR:   result_d = data_operandA | data_operandB;
            OP_SLL:  result_d = shift_res_s;
            OP_SRA:  result_d = shift_res_s;
            default: result_d = {DATA_W{1'b0}};
        endcase
    end

    // Output register; reset clears everything asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= {DATA_W{1'b0}};
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            ne_q     <= ne_d;
            lt_q     <= lt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data_result = result_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: table-driven directed vectors for alu plus hand-written reset sequences.
module tb_alu;

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam bit SHIFT_ON = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  amt;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [31:0] res, input logic ne,
                             input logic lt, input logic ov);
        check({nm, ".result"}, data_result, res);
        check({nm, ".ne"}, {31'd0, isNotEqual}, {31'd0, ne});
        check({nm, ".lt"}, {31'd0, isLessThan}, {31'd0, lt});
        check({nm, ".ovf"}, {31'd0, overflow}, {31'd0, ov});
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] amt);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = amt;
    endtask

    function automatic vec_t mk(input string nm, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] amt,
                                input logic [31:0] res, input logic ne, input logic lt,
                                input logic ov);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.amt = amt;
        v.res = res; v.ne = ne; v.lt = lt; v.ov = ov;
        return v;
    endfunction

    initial begin
        // name, op, A, B, amt, result, ne, lt, ovf
        vecs.push_back(mk("add_0_0",     5'd0, 32'h00000000, 32'h00000000, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("add_min_min", 5'd0, 32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("add_4_4",     5'd0, 32'h40000000, 32'h40000000, 5'd0, 32'h80000000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("add_5_m3",    5'd0, 32'h00000005, 32'hFFFFFFFD, 5'd0, 32'h00000002, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("add_max_1",   5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("sub_0_0",     5'd1, 32'h00000000, 32'h00000000, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("sub_min_min", 5'd1, 32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("sub_min_0f",  5'd1, 32'h80000000, 32'h0F000000, 5'd0, 32'h71000000, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk("sub_3_5",     5'd1, 32'h00000003, 32'h00000005, 5'd0, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("and_f_0",     5'd2, 32'hFFFFFFFF, 32'h00000000, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("and_pat",     5'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("or_f_0",      5'd3, 32'hFFFFFFFF, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("or_pat",      5'd3, 32'h12340000, 32'h00005678, 5'd0, 32'h12345678, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("cmp_pos_neg", 5'd2, 32'h0FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0FFFFFFF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("cmp_ovf",     5'd3, 32'h80000001, 32'h7FFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("op_06",       5'd6, 32'h00000001, 32'h00000002, 5'd3, 32'h00000000, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("op_1f",       5'd31, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sll_1_3",     5'd4, 32'h00000001, 32'h00000000, 5'd3,  SHIFT_ON ? 32'h00000008 : 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sll_1_6",     5'd4, 32'h00000001, 32'h00000000, 5'd6,  SHIFT_ON ? 32'h00000040 : 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sll_1_12",    5'd4, 32'h00000001, 32'h00000000, 5'd12, SHIFT_ON ? 32'h00001000 : 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sll_1_24",    5'd4, 32'h00000001, 32'h00000000, 5'd24, SHIFT_ON ? 32'h01000000 : 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sll_by_0",    5'd4, 32'hDEADBEEF, 32'h00000000, 5'd0,  SHIFT_ON ? 32'hDEADBEEF : 32'h0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("sra_min_4",   5'd5, 32'h80000000, 32'h00000000, 5'd4,  SHIFT_ON ? 32'hF8000000 : 32'h0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("sra_min_31",  5'd5, 32'h80000000, 32'h00000000, 5'd31, SHIFT_ON ? 32'hFFFFFFFF : 32'h0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("sra_pos_31",  5'd5, 32'h40000000, 32'h00000000, 5'd31, 32'h00000000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("sra_by_0",    5'd5, 32'h12345678, 32'h00000000, 5'd0,  SHIFT_ON ? 32'h12345678 : 32'h0, 1'b1, 1'b0, 1'b0));

        // Reset state before any clock edge.
        reset_n = 1'b0;
        drive(5'd0, 32'h00000001, 32'h00000002, 5'd0);
        #2;
        check_all("reset_init", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Table vectors: one-cycle latency, sampled 1 time unit after the edge.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].amt);
            @(posedge clock);
            #1;
            check_all(vecs[i].name, vecs[i].res, vecs[i].ne, vecs[i].lt, vecs[i].ov);
        end

        // Power-of-two doubling sweep; only 2^30 + 2^30 overflows.
        for (int i = 0; i <= 30; i++) begin
            logic [31:0] p;
            p = 32'd1 << i;
            drive(5'd0, p, p, 5'd0);
            @(posedge clock);
            #1;
            check($sformatf("add_pow_%0d.result", i), data_result, 32'd1 << (i + 1));
            check($sformatf("add_pow_%0d.ovf", i), {31'd0, overflow}, (i == 30) ? 32'd1 : 32'd0);
        end

        // Back-to-back: each edge captures its own operation.
        drive(5'd1, 32'h00000010, 32'h00000001, 5'd0);
        @(posedge clock);
        #1;
        check("b2b_first.result", data_result, 32'h0000000F);
        drive(5'd3, 32'h000000F0, 32'h0000000F, 5'd0);
        @(posedge clock);
        #1;
        check("b2b_second.result", data_result, 32'h000000FF);

        // Async reset mid-cycle with nonzero outputs clears immediately.
        drive(5'd1, 32'h80000000, 32'h0F000000, 5'd0);
        @(posedge clock);
        #1;
        check_all("pre_reset", 32'h71000000, 1'b1, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("reset_async", 32'h0, 1'b0, 1'b0, 1'b0);

        // Held across edges, outputs stay zero despite active inputs.
        repeat (2) @(posedge clock);
        #1;
        check_all("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0);

        // Release between edges; the next edge captures current inputs.
        @(negedge clock);
        reset_n = 1'b1;
        drive(5'd0, 32'h00000001, 32'h00000002, 5'd0);
        #1;
        check_all("reset_released_pre_edge", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_all("post_reset", 32'h00000003, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu
